// File: rtl/array4x4_multiplier.sv
// Unsigned 4x4 array multiplier: AND-gate partial products reduced by a ripple array of
// 4 half-adder and 8 full-adder cells, followed by one registered product stage (1-cycle latency).

module half_adder (
    input  logic a_i,
    input  logic b_i,
    output logic s_o,
    output logic c_o
);
    assign s_o = a_i ^ b_i;
    assign c_o = a_i & b_i;
endmodule

module full_adder (
    input  logic a_i,
    input  logic b_i,
    input  logic c_i,
    output logic s_o,
    output logic c_o
);
    assign s_o = a_i ^ b_i ^ c_i;
    assign c_o = (a_i & b_i) | (c_i & (a_i ^ b_i));
endmodule

module array4x4_multiplier (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] A,
    input  logic [3:0] B,
    output logic [7:0] P
);
    logic [3:0] pp [4];
    logic [7:0] p_comb;
    logic [7:0] p_d;
    logic [7:0] p_q;

    // Row r sums (s) and carries (c), indexed by column within the row.
    logic [3:0] s1, c1, s2, c2, s3, c3;

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) begin
                pp[i][j] = A[j] & B[i];
            end
        end
    end

    // Row 1: shifted row 0 plus pp[1]; half adders at both ends.
    half_adder u_r1_0 (.a_i(pp[0][1]), .b_i(pp[1][0]),            .s_o(s1[0]), .c_o(c1[0]));
    full_adder u_r1_1 (.a_i(pp[0][2]), .b_i(pp[1][1]), .c_i(c1[0]), .s_o(s1[1]), .c_o(c1[1]));
    full_adder u_r1_2 (.a_i(pp[0][3]), .b_i(pp[1][2]), .c_i(c1[1]), .s_o(s1[2]), .c_o(c1[2]));
    half_adder u_r1_3 (.a_i(pp[1][3]), .b_i(c1[2]),               .s_o(s1[3]), .c_o(c1[3]));

    // Row 2: previous sums plus pp[2]; top column takes row 1 carry-out.
    half_adder u_r2_0 (.a_i(s1[1]), .b_i(pp[2][0]),            .s_o(s2[0]), .c_o(c2[0]));
    full_adder u_r2_1 (.a_i(s1[2]), .b_i(pp[2][1]), .c_i(c2[0]), .s_o(s2[1]), .c_o(c2[1]));
    full_adder u_r2_2 (.a_i(s1[3]), .b_i(pp[2][2]), .c_i(c2[1]), .s_o(s2[2]), .c_o(c2[2]));
    full_adder u_r2_3 (.a_i(c1[3]), .b_i(pp[2][3]), .c_i(c2[2]), .s_o(s2[3]), .c_o(c2[3]));

    // Row 3: same shape as row 2; its carry-out is product bit 7.
    half_adder u_r3_0 (.a_i(s2[1]), .b_i(pp[3][0]),            .s_o(s3[0]), .c_o(c3[0]));
    full_adder u_r3_1 (.a_i(s2[2]), .b_i(pp[3][1]), .c_i(c3[0]), .s_o(s3[1]), .c_o(c3[1]));
    full_adder u_r3_2 (.a_i(s2[3]), .b_i(pp[3][2]), .c_i(c3[1]), .s_o(s3[2]), .c_o(c3[2]));
    full_adder u_r3_3 (.a_i(c2[3]), .b_i(pp[3][3]), .c_i(c3[2]), .s_o(s3[3]), .c_o(c3[3]));

    assign p_comb = {c3[3], s3[3], s3[2], s3[1], s3[0], s2[0], s1[0], pp[0][0]};
    assign p_d    = p_comb;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p_q <= 8'h00;
        end else begin
            p_q <= p_d;
        end
    end

    assign P = p_q;
endmodule

// File: tb/tb_array4x4_multiplier.sv
// Scoreboard bench: stimulus pushes A*B per applied vector, a monitor pops and compares P
// one edge later; covers reset, directed, exhaustive, random and mid-stream reset cases.

module tb_array4x4_multiplier;
    logic       clk;
    logic       rst_n;
    logic [3:0] a;
    logic [3:0] b;
    logic [7:0] p;

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic [7:0] exp;
    } item_t;

    item_t exp_q[$];
    int    n_cmp;
    int    n_bad;

    array4x4_multiplier dut (
        .clk   (clk),
        .rst_n (rst_n),
        .A     (a),
        .B     (b),
        .P     (p)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] ref_mul(input logic [3:0] x, input logic [3:0] y);
        int unsigned prod;
        prod = 0;
        for (int k = 0; k < int'(y); k++) prod += int'(x);
        return prod[7:0];
    endfunction

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: P=0x%02h expected 0x%02h", name, act, req);
        end
    endtask

    task automatic push_exp(input logic [3:0] x, input logic [3:0] y);
        item_t it;
        it.a   = x;
        it.b   = y;
        it.exp = ref_mul(x, y);
        exp_q.push_back(it);
    endtask

    task automatic apply(input logic [3:0] x, input logic [3:0] y);
        @(negedge clk);
        a = x;
        b = y;
        push_exp(x, y);
    endtask

    // Monitor: the product is presented every cycle once out of reset.
    initial begin
        item_t it;
        forever begin
            @(posedge clk);
            #1;
            if (rst_n && exp_q.size() > 0) begin
                it = exp_q.pop_front();
                check($sformatf("prod %0d*%0d", it.a, it.b), p, it.exp);
            end
        end
    end

    logic [3:0] dir_a [15] = '{8, 4, 12, 4, 4, 12, 13, 7, 14, 13, 5, 15, 0, 1, 11};
    logic [3:0] dir_b [15] = '{4, 6,  9, 7, 5, 15, 15, 7,  7,  7, 7,  7, 13, 11, 1};

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst_n = 1'b1;
        a = 4'd15;
        b = 4'd15;

        // Power-on reset, with the clock running and inputs at maximum.
        #2;
        rst_n = 1'b0;
        #1;
        check("reset_async", p, 8'h00);
        repeat (3) @(posedge clk);
        #1;
        check("reset_hold", p, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        push_exp(4'd15, 4'd15);

        for (int i = 0; i < 15; i++) apply(dir_a[i], dir_b[i]);

        // Constant inputs held over several cycles.
        repeat (6) apply(4'd9, 4'd13);

        // Exhaustive sweep with one mid-stream reset pulse.
        for (int i = 0; i < 256; i++) begin
            if (i == 150) begin
                @(negedge clk);
                a = 4'((i >> 4) & 15);
                b = 4'(i & 15);
                rst_n = 1'b0;
                #1;
                check("midreset_async", p, 8'h00);
                #2;
                rst_n = 1'b1;
                push_exp(a, b);
            end else begin
                apply(4'((i >> 4) & 15), 4'(i & 15));
            end
        end

        for (int i = 0; i < 200; i++) apply(4'($urandom_range(15)), 4'($urandom_range(15)));

        for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(posedge clk);
        #2;
        if (exp_q.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: %0d products pending, expected 0", exp_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
